// File: rtl/mem_bus_arbiter.sv
// Two-master Avalon arbiter: IDLE/OWN0/OWN1 ownership register, combinational forwarding of the owner.
// Latency: 1 cycle to arbitrate from IDLE, 0 once owned; owner parks so back-to-back transfers need no bubble.
module mem_bus_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     m0_address,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_waitrequest,
    input  logic [ADDR_W-1:0]     m1_address,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_waitrequest,
    output logic [ADDR_W-1:0]     s_address,
    output logic                  s_read,
    output logic                  s_write,
    output logic [DATA_W-1:0]     s_writedata,
    output logic [DATA_W/8-1:0]   s_byteenable,
    input  logic [DATA_W-1:0]     s_readdata,
    input  logic                  s_waitrequest,
    output logic [1:0]            grant
);

    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

    state_t r_state;
    logic   r_last;
    logic   w_req0;
    logic   w_req1;

    assign w_req0 = m0_read | m0_write;
    assign w_req1 = m1_read | m1_write;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req0 && w_req1)
                        r_state <= (FIXED_PRIO != 0 || r_last) ? OWN0 : OWN1;
                    else if (w_req0)
                        r_state <= OWN0;
                    else if (w_req1)
                        r_state <= OWN1;
                end
                OWN0: begin
                    // Ownership may move only when the owner is not stalled mid-transfer.
                    if ((!w_req0 || !s_waitrequest) && w_req1 && (!w_req0 || FIXED_PRIO == 0)) begin
                        r_state <= OWN1;
                        r_last  <= 1'b0;
                    end
                end
                OWN1: begin
                    if ((!w_req1 || !s_waitrequest) && w_req0) begin
                        r_state <= OWN0;
                        r_last  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign m0_readdata = s_readdata;
    assign m1_readdata = s_readdata;

    // Gated by reset as well so strobes drop the instant reset asserts.
    always_comb begin
        s_address      = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_writedata    = '0;
        s_byteenable   = '0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        grant          = 2'b00;
        if (reset) begin
            case (r_state)
                OWN0: begin
                    s_address      = m0_address;
                    s_read         = m0_read;
                    s_write        = m0_write;
                    s_writedata    = m0_writedata;
                    s_byteenable   = m0_byteenable;
                    m0_waitrequest = s_waitrequest;
                    grant          = 2'b01;
                end
                OWN1: begin
                    s_address      = m1_address;
                    s_read         = m1_read;
                    s_write        = m1_write;
                    s_writedata    = m1_writedata;
                    s_byteenable   = m1_byteenable;
                    m1_waitrequest = s_waitrequest;
                    grant          = 2'b10;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: vector table plus hand sequences for priority and reset corners.
module tb_mem_bus_arbiter;

    localparam logic [31:0] WD0 = 32'h1111_0000;
    localparam logic [31:0] WD1 = 32'h2222_0000;
    localparam logic [3:0]  BE0 = 4'hF;
    localparam logic [3:0]  BE1 = 4'h3;
    localparam logic [31:0] RD  = 32'hDEAD_BEEF;

    logic        clk, reset;
    logic [31:0] m0_address, m0_writedata, m1_address, m1_writedata, s_readdata;
    logic        m0_read, m0_write, m1_read, m1_write, s_waitrequest;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic [31:0] m0_readdata, m1_readdata, s_address, s_writedata;
    logic        m0_waitrequest, m1_waitrequest, s_read, s_write;
    logic [3:0]  s_byteenable;
    logic [1:0]  grant;
    logic [31:0] fp_m0_readdata, fp_m1_readdata, fp_s_address, fp_s_writedata;
    logic        fp_m0_waitrequest, fp_m1_waitrequest, fp_s_read, fp_s_write;
    logic [3:0]  fp_s_byteenable;
    logic [1:0]  fp_grant;

    int n_chk = 0;
    int n_err = 0;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_readdata(s_readdata), .s_waitrequest(s_waitrequest), .grant(grant)
    );

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_readdata(fp_m0_readdata), .m0_waitrequest(fp_m0_waitrequest),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_readdata(fp_m1_readdata), .m1_waitrequest(fp_m1_waitrequest),
        .s_address(fp_s_address), .s_read(fp_s_read), .s_write(fp_s_write),
        .s_writedata(fp_s_writedata), .s_byteenable(fp_s_byteenable),
        .s_readdata(s_readdata), .s_waitrequest(s_waitrequest), .grant(fp_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd0, wr0;
        logic [31:0] a0;
        logic        rd1, wr1;
        logic [31:0] a1;
        logic        sw;
        logic [1:0]  g;
        logic        srd, swr;
        logic [31:0] sa;
        logic        w0, w1;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic rd0, logic wr0, logic [31:0] a0,
                                logic rd1, logic wr1, logic [31:0] a1, logic sw,
                                logic [1:0] g, logic srd, logic swr, logic [31:0] sa,
                                logic w0, logic w1);
        vec_t v;
        v.rd0 = rd0; v.wr0 = wr0; v.a0 = a0;
        v.rd1 = rd1; v.wr1 = wr1; v.a1 = a1; v.sw = sw;
        v.g = g; v.srd = srd; v.swr = swr; v.sa = sa; v.w0 = w0; v.w1 = w1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rd0, input logic wr0, input logic [31:0] a0,
                         input logic rd1, input logic wr1, input logic [31:0] a1, input logic sw);
        m0_read = rd0; m0_write = wr0; m0_address = a0;
        m1_read = rd1; m1_write = wr1; m1_address = a1;
        s_waitrequest = sw;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(0, 0, 32'h0, 0, 0, 32'h0, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        logic [31:0] exp_wd;
        logic [3:0]  exp_be;
        reset = 1'b0;
        m0_writedata = WD0; m1_writedata = WD1;
        m0_byteenable = BE0; m1_byteenable = BE1;
        s_readdata = RD;
        drive(0, 0, 32'h0, 0, 0, 32'h0, 0);

        // m0 read, then parked back-to-back reads
        tv.push_back(mk(1,0,32'hBFC0_0000, 0,0,32'h0,     0, 2'b00,0,0,32'h0,        1,1));
        tv.push_back(mk(1,0,32'hBFC0_0000, 0,0,32'h0,     0, 2'b01,1,0,32'hBFC0_0000,0,1));
        tv.push_back(mk(1,0,32'h10,        0,0,32'h0,     0, 2'b01,1,0,32'h10,       0,1));
        tv.push_back(mk(1,0,32'h14,        0,0,32'h0,     0, 2'b01,1,0,32'h14,       0,1));
        tv.push_back(mk(1,0,32'h18,        0,0,32'h0,     0, 2'b01,1,0,32'h18,       0,1));
        // stalled m0 write with m1 read arriving
        tv.push_back(mk(0,1,32'h100,       0,0,32'h0,     1, 2'b01,0,1,32'h100,      1,1));
        tv.push_back(mk(0,1,32'h100,       1,0,32'h200,   1, 2'b01,0,1,32'h100,      1,1));
        tv.push_back(mk(0,1,32'h100,       1,0,32'h200,   1, 2'b01,0,1,32'h100,      1,1));
        tv.push_back(mk(0,1,32'h100,       1,0,32'h200,   0, 2'b01,0,1,32'h100,      0,1));
        tv.push_back(mk(0,0,32'h100,       1,0,32'h200,   0, 2'b10,1,0,32'h200,      1,0));
        // round-robin under continuous contention
        tv.push_back(mk(1,0,32'h300,       1,0,32'h400,   0, 2'b10,1,0,32'h400,      1,0));
        tv.push_back(mk(1,0,32'h300,       1,0,32'h400,   0, 2'b01,1,0,32'h300,      0,1));
        tv.push_back(mk(1,0,32'h300,       1,0,32'h400,   0, 2'b10,1,0,32'h400,      1,0));
        tv.push_back(mk(1,0,32'h300,       1,0,32'h400,   0, 2'b01,1,0,32'h300,      0,1));
        // m1 stalls then abandons its read; m0 takes over
        tv.push_back(mk(1,0,32'h300,       1,0,32'h400,   1, 2'b10,1,0,32'h400,      1,1));
        tv.push_back(mk(1,0,32'h300,       0,0,32'h400,   1, 2'b10,0,0,32'h400,      1,1));
        tv.push_back(mk(1,0,32'h300,       0,0,32'h400,   0, 2'b01,1,0,32'h300,      0,1));

        repeat (2) @(posedge clk);
        #1;
        chk("reset_grant", {30'b0, grant}, 32'h0);
        chk("reset_s_read", {31'b0, s_read}, 32'h0);
        chk("reset_m0_wait", {31'b0, m0_waitrequest}, 32'h1);
        reset = 1'b1;

        foreach (tv[i]) begin
            drive(tv[i].rd0, tv[i].wr0, tv[i].a0, tv[i].rd1, tv[i].wr1, tv[i].a1, tv[i].sw);
            #2;
            exp_wd = (tv[i].g == 2'b01) ? WD0 : (tv[i].g == 2'b10) ? WD1 : 32'h0;
            exp_be = (tv[i].g == 2'b01) ? BE0 : (tv[i].g == 2'b10) ? BE1 : 4'h0;
            chk($sformatf("v%0d_grant", i), {30'b0, grant}, {30'b0, tv[i].g});
            chk($sformatf("v%0d_s_read", i), {31'b0, s_read}, {31'b0, tv[i].srd});
            chk($sformatf("v%0d_s_write", i), {31'b0, s_write}, {31'b0, tv[i].swr});
            chk($sformatf("v%0d_s_addr", i), s_address, tv[i].sa);
            chk($sformatf("v%0d_s_wdata", i), s_writedata, exp_wd);
            chk($sformatf("v%0d_s_be", i), {28'b0, s_byteenable}, {28'b0, exp_be});
            chk($sformatf("v%0d_m0_wait", i), {31'b0, m0_waitrequest}, {31'b0, tv[i].w0});
            chk($sformatf("v%0d_m1_wait", i), {31'b0, m1_waitrequest}, {31'b0, tv[i].w1});
            chk($sformatf("v%0d_m0_rdata", i), m0_readdata, RD);
            chk($sformatf("v%0d_m1_rdata", i), m1_readdata, RD);
            @(posedge clk);
            #1;
        end

        // Continuous contention from reset: round-robin alternates, fixed priority keeps m0.
        do_reset();
        drive(1, 0, 32'h600, 1, 0, 32'h700, 0);
        #2;
        chk("rr_c0_grant", {30'b0, grant}, 32'h0);
        chk("fp_c0_grant", {30'b0, fp_grant}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #2;
            chk($sformatf("rr_c%0d_grant", k + 1), {30'b0, grant}, (k % 2 == 0) ? 32'h1 : 32'h2);
            chk($sformatf("fp_c%0d_grant", k + 1), {30'b0, fp_grant}, 32'h1);
            chk($sformatf("fp_c%0d_m1_wait", k + 1), {31'b0, fp_m1_waitrequest}, 32'h1);
        end

        // Reset hitting a stalled m1 write, then re-request after release.
        do_reset();
        drive(0, 0, 32'h0, 0, 1, 32'h500, 1);
        #2;
        chk("rst_idle_grant", {30'b0, grant}, 32'h0);
        @(posedge clk);
        #2;
        chk("rst_own1_grant", {30'b0, grant}, 32'h2);
        chk("rst_own1_write", {31'b0, s_write}, 32'h1);
        reset = 1'b0;
        #1;
        chk("rst_async_write", {31'b0, s_write}, 32'h0);
        chk("rst_async_grant", {30'b0, grant}, 32'h0);
        chk("rst_async_m1_wait", {31'b0, m1_waitrequest}, 32'h1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        s_waitrequest = 1'b0;
        #1;
        chk("rel_grant", {30'b0, grant}, 32'h0);
        chk("rel_write", {31'b0, s_write}, 32'h0);
        @(posedge clk);
        #2;
        chk("regrant_grant", {30'b0, grant}, 32'h2);
        chk("regrant_write", {31'b0, s_write}, 32'h1);
        chk("regrant_addr", s_address, 32'h500);
        chk("regrant_m1_wait", {31'b0, m1_waitrequest}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
